// File: rtl/booth_pkg.sv
// booth_pkg: shared state, digit and sizing definitions for the radix-4 Booth multiplier
package booth_pkg;
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   typedef struct packed {
      logic neg;
      logic two;
      logic zero;
   } digit_t;
   function automatic int digit_count(input int width);
      return width / 2 + 1;
   endfunction
endpackage

// File: rtl/booth_r4_recoder.sv
// booth_r4_recoder: maps a 3-bit Booth window {x[2i+1], x[2i], x[2i-1]} to a signed digit
module booth_r4_recoder
   import booth_pkg::*;
(
   input  logic [2:0] window,
   output digit_t     digit
);
   assign digit.neg  = window[2];
   assign digit.two  = (window == 3'b011) || (window == 3'b100);
   assign digit.zero = (window == 3'b000) || (window == 3'b111);
endmodule

// File: rtl/booth_r4_mult.sv
// booth_r4_mult: iterative radix-4 Booth multiplier, one digit per clock, signed/unsigned.
// Define BOOTH_EARLY_EXIT_EN to stop once all remaining digits are zero.
module booth_r4_mult
   import booth_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic               signed_mode,
   input  logic [WIDTH-1:0]   x_value,
   input  logic [WIDTH-1:0]   y_value,
   output logic               busy,
   output logic               ready,
   output logic [2*WIDTH-1:0] total_product
);
   localparam int N  = digit_count(WIDTH);
   localparam int IW = $clog2(N + 1);
   localparam int XW = WIDTH + 3;
   localparam int PW = 2 * WIDTH;

   state_t        state, state_next;
   logic [XW-1:0] x_reg;
   logic [PW-1:0] y_reg, acc, acc_next, mag, pp, product;
   logic [IW-1:0] idx;
   logic [2:0]    window;
   digit_t        digit;
   logic          finished, last, exit_ok;

   // x_reg bit 0 is the implicit x[-1], so digit i's window starts at bit 2i
   assign window   = 3'(x_reg >> {idx, 1'b0});
   assign finished = idx == IW'(N);
   assign last     = idx == IW'(N - 1);

   booth_r4_recoder u_recoder (
      .window (window),
      .digit  (digit)
   );

   assign mag      = digit.two ? {y_reg[PW-2:0], 1'b0} : y_reg;
   assign pp       = digit.zero ? '0 : digit.neg ? -mag : mag;
   assign acc_next = acc + (pp << {idx, 1'b0});

`ifdef BOOTH_EARLY_EXIT_EN
   logic [XW-1:0] x_rest;
   // remaining digits are all zero once the bits above this window are pure sign copies
   assign x_rest  = $signed(x_reg) >>> ({idx, 1'b0} + (IW + 1)'(2));
   assign exit_ok = (x_rest == '0) || (x_rest == '1);
`else
   assign exit_ok = 1'b0;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         x_reg   <= '0;
         y_reg   <= '0;
         acc     <= '0;
         idx     <= '0;
         product <= '0;
      end else begin
         state <= state_next;
         if (state == IDLE && start) begin
            x_reg <= {{2{signed_mode & x_value[WIDTH-1]}}, x_value, 1'b0};
            y_reg <= {{WIDTH{signed_mode & y_value[WIDTH-1]}}, y_value};
            acc   <= '0;
            idx   <= '0;
         end else if (state == CALC) begin
            if (finished) product <= acc;
            else begin
               acc <= acc_next;
               idx <= (last || exit_ok) ? IW'(N) : idx + 1'b1;
            end
         end
      end
   end

   always_comb begin
      state_next = state;
      state_next = (state == IDLE) ? (start ? CALC : IDLE) :
                   (state == CALC) ? (finished ? DONE : CALC) : IDLE;
   end

   assign busy          = state != IDLE;
   assign ready         = state == DONE;
   assign total_product = product;
endmodule

// File: tb/tb_booth_r4_mult.sv
// tb_booth_r4_mult: random and directed checks of booth_r4_mult against an arithmetic reference
module tb_booth_r4_mult;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        sm = 1'b0;
   logic        st8 = 1'b0, st16 = 1'b0;
   logic [7:0]  x8 = '0, y8 = '0;
   logic [15:0] x16 = '0, y16 = '0;
   logic        busy8, ready8, busy16, ready16;
   logic [15:0] p8;
   logic [31:0] p16;
   int          n_cmp = 0, n_bad = 0;

   always #5 clock = ~clock;

   booth_r4_mult #(.WIDTH(8)) dut8 (
      .clock(clock), .reset(reset), .start(st8), .signed_mode(sm),
      .x_value(x8), .y_value(y8), .busy(busy8), .ready(ready8), .total_product(p8)
   );

   booth_r4_mult #(.WIDTH(16)) dut16 (
      .clock(clock), .reset(reset), .start(st16), .signed_mode(sm),
      .x_value(x16), .y_value(y16), .busy(busy16), .ready(ready16), .total_product(p16)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic longint sx(input logic [15:0] v, input int w, input bit m);
      longint r = longint'(v);
      return (m && v[w-1]) ? r - (longint'(1) << w) : r;
   endfunction

   function automatic longint model_prod(input logic [15:0] x, input logic [15:0] y, input int w, input bit m);
      return (sx(x, w, m) * sx(y, w, m)) & ((longint'(1) << (2 * w)) - 1);
   endfunction

   function automatic int model_lat(input logic [15:0] x, input int w, input bit m);
      int n = w / 2 + 1;
`ifdef BOOTH_EARLY_EXIT_EN
      longint xe = sx(x, w, m);
      for (int i = 0; i < n; i++)
         if ((xe >>> (2 * i + 1)) == 0 || (xe >>> (2 * i + 1)) == -1) return i + 2;
`endif
      return n + 1;
   endfunction

   task automatic run(input bit w16, input bit m, input logic [15:0] x, input logic [15:0] y,
                      output int lat, output logic [31:0] prod);
      @(negedge clock);
      sm = m;
      if (w16) begin x16 = x; y16 = y; st16 = 1'b1; end
      else begin x8 = x[7:0]; y8 = y[7:0]; st8 = 1'b1; end
      @(posedge clock);
      #1;
      st8 = 1'b0; st16 = 1'b0;
      x8 = 8'($urandom); y8 = 8'($urandom); x16 = 16'($urandom); y16 = 16'($urandom);
      sm = 1'($urandom);
      lat = 0;
      prod = '0;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clock);
         #1;
         if (w16 ? ready16 : ready8) begin
            lat = c;
            prod = w16 ? p16 : {16'b0, p8};
            break;
         end
      end
   endtask

   task automatic check_op(input string tag, input bit w16, input bit m, input logic [15:0] x, input logic [15:0] y);
      int w = w16 ? 16 : 8;
      int lat;
      logic [31:0] prod;
      run(w16, m, x, y, lat, prod);
      chk({tag, " product"}, 64'(prod), 64'(model_prod(x, y, w, m)));
      chk({tag, " latency"}, 64'(lat), 64'(model_lat(x, w, m)));
      @(posedge clock);
      #1;
      chk({tag, " ready fall"}, 64'(w16 ? ready16 : ready8), 64'(0));
      chk({tag, " busy fall"}, 64'(w16 ? busy16 : busy8), 64'(0));
   endtask

   initial begin
      int pulses, lat;
      logic [15:0] got;
      #12;
      chk("reset busy", 64'(busy8), 64'(0));
      chk("reset ready", 64'(ready8), 64'(0));
      chk("reset product", 64'(p8), 64'(0));
      @(negedge clock);
      reset = 1'b0;

      check_op("u255x255", 1'b0, 1'b0, 16'h00ff, 16'h00ff);
      check_op("s-128x-128", 1'b0, 1'b1, 16'h0080, 16'h0080);
      check_op("s-1x127", 1'b0, 1'b1, 16'h00ff, 16'h007f);
      check_op("u0x200", 1'b0, 1'b0, 16'h0000, 16'd200);
      check_op("u1x77", 1'b0, 1'b0, 16'h0001, 16'd77);
      check_op("s-1x5", 1'b0, 1'b1, 16'h00ff, 16'h0005);
      check_op("s127x-128", 1'b0, 1'b1, 16'h007f, 16'h0080);

      // restarts during the operation must be ignored
      @(negedge clock);
      sm = 1'b0; x8 = 8'ha5; y8 = 8'h3c; st8 = 1'b1;
      @(posedge clock);
      pulses = 0; lat = 0; got = '0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clock);
         st8 = (c <= 5);
         x8 = 8'($urandom); y8 = 8'($urandom); sm = 1'($urandom);
         @(posedge clock);
         #1;
         if (ready8) begin pulses++; lat = c; got = p8; end
      end
      st8 = 1'b0;
      chk("restart pulses", 64'(pulses), 64'(1));
      chk("restart product", 64'(got), 64'(model_prod(16'h00a5, 16'h003c, 8, 1'b0)));
      chk("restart latency", 64'(lat), 64'(model_lat(16'h00a5, 8, 1'b0)));

      // asynchronous reset in the middle of an operation
      @(negedge clock);
      sm = 1'b0; x8 = 8'h7f; y8 = 8'd9; st8 = 1'b1;
      @(posedge clock);
      #1;
      st8 = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      chk("mid busy", 64'(busy8), 64'(1));
      #1;
      reset = 1'b1;
      #1;
      chk("async busy", 64'(busy8), 64'(0));
      chk("async ready", 64'(ready8), 64'(0));
      chk("async product", 64'(p8), 64'(0));
      @(negedge clock);
      reset = 1'b0;
      check_op("after reset 3x5", 1'b0, 1'b0, 16'd3, 16'd5);

      for (int i = 0; i < 1000; i++)
         check_op("rnd16", 1'b1, 1'($urandom), 16'($urandom), 16'($urandom));
      check_op("s16 min", 1'b1, 1'b1, 16'h8000, 16'h8000);
      check_op("u16 max", 1'b1, 1'b0, 16'hffff, 16'hffff);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
